// File: rtl/data_mem_responder.sv
// Word-addressed data memory acting as the responder end of the CPU data-memory
// request/response interface. Accepts one request at a time, waits LATENCY cycles,
// commits the access and holds the response until the core takes it.
module data_mem_responder #(
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AddrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] AddrLimit = 32'(DEPTH * 4);
   localparam logic [3:0]  CntInit   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem [DEPTH];

   logic             accept;
   logic             commit;
   logic             cur_we;
   logic [31:0]      cur_addr;
   logic [31:0]      cur_wdata;
   logic [3:0]       cur_be;
   logic             cur_err;
   logic [AddrW-1:0] cur_idx;
   logic             mem_we;

   // Select the request being committed: live inputs when LATENCY=0 commits on accept,
   // otherwise the copy latched at accept.
   always_comb begin
      accept    = (state_q == StIdle) && req_valid;
      commit    = (accept && (LATENCY == 0)) || ((state_q == StWait) && (cnt_q == 4'd0));
      cur_we    = (state_q == StIdle) ? req_we    : we_q;
      cur_addr  = (state_q == StIdle) ? req_addr  : addr_q;
      cur_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
      cur_be    = (state_q == StIdle) ? req_be    : be_q;
      // Full 32-bit compare so high address bits never alias into the array
      cur_err   = (cur_addr[1:0] != 2'b00) || (cur_addr >= AddrLimit);
      cur_idx   = cur_addr[AddrW+1:2];
      mem_we    = commit && cur_we && !cur_err;
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (req_valid) state_d = (LATENCY == 0) ? StResp : StWait;
         StWait: if (cnt_q == 4'd0) state_d = StResp;
         StResp: if (rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Request latch, wait counter and response data
   always_comb begin
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      if (accept) begin
         cnt_d   = CntInit;
         we_d    = req_we;
         addr_d  = req_addr;
         wdata_d = req_wdata;
         be_d    = req_be;
      end else if ((state_q == StWait) && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
      if (commit) begin
         err_d   = cur_err;
         rdata_d = (cur_err || cur_we) ? 32'd0 : mem[cur_idx];
      end else if ((state_q == StResp) && rsp_ready) begin
         err_d   = 1'b0;
         rdata_d = 32'd0;
      end
   end

   // Byte-masked store on the commit edge; array contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
         end
      end
   end

   // Handshake outputs decoded from state
   always_comb begin
      req_ready = (state_q == StIdle);
      rsp_valid = (state_q == StResp);
      rsp_rdata = rdata_q;
      rsp_err   = err_q;
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 instance for most scenarios,
// LATENCY=0 instance for the back-to-back stream.
module tb_data_mem_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
   logic [31:0] req_addr, req_wdata, rsp_rdata;
   logic [3:0]  req_be;

   logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
   logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
   logic [3:0]  b_req_be;

   int total = 0;
   int bad   = 0;

   data_mem_responder #(.DEPTH(64), .LATENCY(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   data_mem_responder #(.DEPTH(64), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
      .rsp_err(b_rsp_err)
   );

   // One full transaction on the LATENCY=2 instance; caller sits #1 after an edge.
   // lat = edges after the accept edge until rsp_valid is seen (99 if never accepted).
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rdata, output logic err,
                         output int lat);
      int n;
      req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      rsp_ready = 1'b1; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      if (n >= 50) lat = 99;
      rdata = rsp_rdata;
      err   = rsp_err;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
      total++; if (rsp_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); end
      total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", rsp_err); end
      total++; if (b_req_ready !== 1'b1) begin bad++; $display("FAIL rst_b_req_ready got=%b exp=1", b_req_ready); end
      rst = 1'b0;
      @(posedge clk); #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_req_ready got=%b exp=1", req_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL post_rst_rsp_valid got=%b exp=0", rsp_valid); end
   endtask

   task automatic test_store_load;
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
      total++; if (lat != 2) begin bad++; $display("FAIL st_latency got=%0d exp=2", lat); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL st_err got=%b exp=0", er); end
      total++; if (rd !== 32'd0) begin bad++; $display("FAIL st_rdata got=%h exp=0", rd); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL st_pulse got=%b exp=0", rsp_valid); end
      total++; if (rsp_rdata !== 32'd0) begin bad++; $display("FAIL st_clear got=%h exp=0", rsp_rdata); end
      do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      total++; if (lat != 2) begin bad++; $display("FAIL ld_latency got=%0d exp=2", lat); end
      total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_rdata got=%h exp=deadbeef", rd); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL ld_err got=%b exp=0", er); end
   endtask

   task automatic test_byte_enable;
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
      do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
      total++; if (er !== 1'b0) begin bad++; $display("FAIL be_st_err got=%b exp=0", er); end
      do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
      total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL be_rdata got=%h exp=11bb33dd", rd); end
   endtask

   task automatic test_errors;
      logic [31:0] rd; logic er; int lat;
      do_req(1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
      total++; if (er !== 1'b1) begin bad++; $display("FAIL misalign_err got=%b exp=1", er); end
      total++; if (rd !== 32'd0) begin bad++; $display("FAIL misalign_rdata got=%h exp=0", rd); end
      do_req(1'b1, 32'hFC, 32'h5A5A0001, 4'hF, rd, er, lat);
      total++; if (er !== 1'b0) begin bad++; $display("FAIL top_st_err got=%b exp=0", er); end
      do_req(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, rd, er, lat);
      total++; if (er !== 1'b1) begin bad++; $display("FAIL range_err got=%b exp=1", er); end
      total++; if (rd !== 32'd0) begin bad++; $display("FAIL range_rdata got=%h exp=0", rd); end
      do_req(1'b0, 32'hFC, 32'h0, 4'h0, rd, er, lat);
      total++; if (er !== 1'b0) begin bad++; $display("FAIL top_ld_err got=%b exp=0", er); end
      total++; if (rd !== 32'h5A5A0001) begin bad++; $display("FAIL top_ld_rdata got=%h exp=5a5a0001", rd); end
      do_req(1'b1, 32'hFC, 32'h0, 4'h0, rd, er, lat);
      total++; if (er !== 1'b0) begin bad++; $display("FAIL be0_err got=%b exp=0", er); end
      do_req(1'b0, 32'hFC, 32'h0, 4'h0, rd, er, lat);
      total++; if (rd !== 32'h5A5A0001) begin bad++; $display("FAIL be0_rdata got=%h exp=5a5a0001", rd); end
      // High address bit set must not alias onto word 0x10
      do_req(1'b1, 32'h80000010, 32'h0, 4'hF, rd, er, lat);
      total++; if (er !== 1'b1) begin bad++; $display("FAIL high_err got=%b exp=1", er); end
      do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL nowrap_rdata got=%h exp=deadbeef", rd); end
   endtask

   task automatic test_backpressure;
      int n;
      rsp_ready = 1'b0;
      req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'h0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_addr = 32'h20;
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      total++; if (n != 2) begin bad++; $display("FAIL bp_latency got=%0d exp=2", n); end
      for (int i = 0; i < 5; i++) begin
         total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, rsp_valid); end
         total++; if (rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL bp_rdata[%0d] got=%h exp=deadbeef", i, rsp_rdata); end
         total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready[%0d] got=%b exp=0", i, req_ready); end
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", rsp_valid); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", req_ready); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_next_accept got=%b exp=0", req_ready); end
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      total++; if (n != 2) begin bad++; $display("FAIL bp_next_latency got=%0d exp=2", n); end
      total++; if (rsp_rdata !== 32'h11BB33DD) begin bad++; $display("FAIL bp_next_rdata got=%h exp=11bb33dd", rsp_rdata); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      logic [31:0] rd; logic er; int lat; int n; logic seen;
      do_req(1'b1, 32'h30, 32'h0, 4'hF, rd, er, lat);
      req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
      rsp_ready = 1'b1; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b exp=0", rsp_valid); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", req_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      repeat (5) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_rsp got=%b exp=0", seen); end
      do_req(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
      total++; if (rd !== 32'd0) begin bad++; $display("FAIL abort_mem got=%h exp=0", rd); end
      // Reset after commit: store persists, response dropped
      req_we = 1'b1; req_addr = 32'h34; req_wdata = 32'h12345678; req_be = 4'hF;
      rsp_ready = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      total++; if (n != 2) begin bad++; $display("FAIL commit_latency got=%0d exp=2", n); end
      rst = 1'b1;
      #1;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL commit_drop got=%b exp=0", rsp_valid); end
      @(posedge clk); #1;
      rst = 1'b0;
      do_req(1'b0, 32'h34, 32'h0, 4'h0, rd, er, lat);
      total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL commit_mem got=%h exp=12345678", rd); end
   endtask

   task automatic test_back_to_back;
      logic        v_we [6];
      logic [31:0] v_addr [6];
      logic [31:0] v_wdata [6];
      logic [31:0] v_exp [6];
      int acc_cyc [6];
      int idx, ridx, cyc;
      logic will;
      v_we    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      v_addr  = '{32'h40, 32'h44, 32'h40, 32'h44, 32'h40, 32'h40};
      v_wdata = '{32'hA1B2C3D4, 32'h0F0F0F0F, 32'h0, 32'h0, 32'h55667788, 32'h0};
      v_exp   = '{32'h0, 32'h0, 32'hA1B2C3D4, 32'h0F0F0F0F, 32'h0, 32'h55667788};
      for (int i = 0; i < 6; i++) acc_cyc[i] = 0;
      idx = 0; ridx = 0; cyc = 0;
      b_rsp_ready = 1'b1; b_req_be = 4'hF;
      b_req_we = v_we[0]; b_req_addr = v_addr[0]; b_req_wdata = v_wdata[0];
      b_req_valid = 1'b1;
      while (ridx < 6 && cyc < 60) begin
         will = b_req_ready && b_req_valid;
         @(posedge clk); #1;
         cyc++;
         if (will) begin
            acc_cyc[idx] = cyc;
            idx++;
            if (idx < 6) begin
               b_req_we = v_we[idx]; b_req_addr = v_addr[idx]; b_req_wdata = v_wdata[idx];
            end else begin
               b_req_valid = 1'b0;
            end
         end
         if (b_rsp_valid) begin
            total++; if (b_rsp_rdata !== v_exp[ridx]) begin bad++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", ridx, b_rsp_rdata, v_exp[ridx]); end
            total++; if (b_rsp_err !== 1'b0) begin bad++; $display("FAIL b2b_err[%0d] got=%b exp=0", ridx, b_rsp_err); end
            ridx++;
         end
      end
      total++; if (ridx != 6) begin bad++; $display("FAIL b2b_rsp_count got=%0d exp=6", ridx); end
      for (int i = 1; i < 6; i++) begin
         total++;
         if (acc_cyc[i] - acc_cyc[i-1] != 2) begin
            bad++; $display("FAIL b2b_spacing[%0d] got=%0d exp=2", i, acc_cyc[i] - acc_cyc[i-1]);
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
      rsp_ready = 1'b1;
      b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'h0; b_req_wdata = 32'h0;
      b_req_be = 4'h0; b_rsp_ready = 1'b1;
      #1 rst = 1'b1;
      test_reset();
      test_store_load();
      test_byte_enable();
      test_errors();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
